// File: rtl/program_loader.sv
// Instruction-memory loader: parses SYNC/LEN/payload/CSUM frames from a host byte
// stream, writes the payload from address 0 and releases the processor on a clean load.
module program_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MAX_WORDS = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_REPORT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] count;
  logic [7:0]       sum;
  logic [TMR_W-1:0] timer;

  logic xfer_c;
  logic in_frame_c;
  logic expire_c;
  logic len_bad_c;

  assign xfer_c     = in_valid & in_ready;
  assign in_frame_c = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  // Expiry fires on the idle cycle that would bring the gap count to TIMEOUT;
  // a byte arriving in that cycle wins because expiry requires no transfer.
  assign expire_c   = in_frame_c && !xfer_c && (timer == TMR_W'(TIMEOUT - 1));
  assign len_bad_c  = (in_data == 8'd0) || (32'(in_data) > MAX_WORDS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      len          <= '0;
      count        <= '0;
      sum          <= '0;
      timer        <= '0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we     <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;

      // Inter-byte idle timer, only meaningful inside a frame
      if (in_frame_c) begin
        if (xfer_c) begin
          timer <= '0;
        end else begin
          timer <= timer + TMR_W'(1);
        end
      end

      if (expire_c) begin
        state      <= S_REPORT;
        in_ready   <= 1'b0;
        load_error <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (xfer_c && (in_data == SYNC_BYTE)) begin
              state    <= S_LEN;
              cpu_hold <= 1'b1;
              timer    <= '0;
            end
          end

          S_LEN: begin
            if (xfer_c) begin
              if (len_bad_c) begin
                state      <= S_REPORT;
                in_ready   <= 1'b0;
                load_error <= 1'b1;
              end else begin
                len   <= CNT_W'(in_data);
                sum   <= in_data;
                count <= '0;
                state <= S_DATA;
              end
            end
          end

          S_DATA: begin
            if (xfer_c) begin
              mem_we    <= 1'b1;
              mem_addr  <= count[ADDR_W-1:0];
              mem_wdata <= in_data;
              sum       <= sum + in_data;
              count     <= count + CNT_W'(1);
              if ((count + CNT_W'(1)) == len) begin
                state <= S_CSUM;
              end
            end
          end

          S_CSUM: begin
            if (xfer_c) begin
              state    <= S_REPORT;
              in_ready <= 1'b0;
              if (in_data == sum) begin
                load_done    <= 1'b1;
                cpu_hold     <= 1'b0;
                words_loaded <= len;
              end else begin
                load_error <= 1'b1;
              end
            end
          end

          S_REPORT: begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end

          default: begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model compared every cycle,
// plus directed frames with literal expectations.
module tb_program_loader;

  localparam int unsigned AW   = 5;
  localparam int unsigned MAXW = 32;
  localparam int unsigned TMO  = 8;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  program_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks a frame as a buffer of accepted bytes
  bit          m_in_frame;
  logic [7:0]  m_fr[$];
  int          m_idle;
  int          m_len;
  logic        e_ready, e_we, e_hold, e_done, e_err;
  logic [AW-1:0] e_addr;
  logic [7:0]  e_wdata;
  logic [AW:0] e_words;

  function automatic void model_reset();
    m_in_frame = 1'b0;
    m_fr.delete();
    m_idle = 0;
    m_len = 0;
    e_ready = 1'b1; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0; e_words = '0;
  endfunction

  function automatic void model_finish(input bit ok);
    m_in_frame = 1'b0;
    e_ready = 1'b0;
    if (ok) begin
      e_done = 1'b1;
      e_hold = 1'b0;
      e_words = (AW+1)'(m_len);
    end else begin
      e_err = 1'b1;
    end
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d);
    logic x;
    int unsigned s;
    x = v && e_ready;
    e_we = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
    if (!m_in_frame) begin
      if (x && d == 8'hA5) begin
        m_in_frame = 1'b1;
        m_fr.delete();
        m_idle = 0;
        e_hold = 1'b1;
      end
    end else if (x) begin
      m_idle = 0;
      m_fr.push_back(d);
      if (m_fr.size() == 1) begin
        m_len = int'(d);
        if (m_len == 0 || m_len > int'(MAXW)) model_finish(1'b0);
      end else if (m_fr.size() <= m_len + 1) begin
        e_we = 1'b1;
        e_addr = AW'(m_fr.size() - 2);
        e_wdata = d;
      end else begin
        s = 0;
        for (int i = 0; i <= m_len; i++) s += int'(m_fr[i]);
        model_finish(8'(s) == d);
      end
    end else begin
      m_idle++;
      if (m_idle == int'(TMO)) model_finish(1'b0);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step(in_valid, in_data);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      if (e_we || !reset) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      chk("load_done", 32'(load_done), 32'(e_done));
      chk("load_error", 32'(load_error), 32'(e_err));
      if (e_ready || !reset) begin
        chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
        chk("words_loaded", 32'(words_loaded), 32'(e_words));
      end
    end
  end

  // Observed memory image and event counts from the DUT outputs
  logic [7:0] dmem [32];
  int done_cnt = 0, err_cnt = 0, we_cnt = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      dmem[mem_addr] = mem_wdata;
      we_cnt++;
    end
    if (load_done === 1'b1) done_cnt++;
    if (load_error === 1'b1) err_cnt++;
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic r;
    int tries;
    idle(gap);
    in_valid = 1'b1;
    in_data = b;
    r = 1'b0;
    tries = 0;
    while (!r && tries < 8) begin
      r = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    chk("handshake", 32'(r), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t q, input int gap);
    int g;
    foreach (q[i]) begin
      g = (gap < 0) ? int'($urandom_range(0, TMO - 1)) : gap;
      send(q[i], g);
    end
  endtask

  function automatic bq_t make_frame(input bq_t d);
    bq_t f;
    logic [7:0] s;
    s = 8'(d.size());
    f.push_back(8'hA5);
    f.push_back(8'(d.size()));
    foreach (d[i]) begin
      f.push_back(d[i]);
      s = s + d[i];
    end
    f.push_back(s);
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f1, q;
    logic [7:0] t1d [6];
    int d0, e0, w0;
    t1d = '{8'h09, 8'h29, 8'h49, 8'h69, 8'h89, 8'hA9};
    f1 = '{8'hA5, 8'h06, 8'h09, 8'h29, 8'h49, 8'h69, 8'h89, 8'hA9, 8'h1C};
    model_reset();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // Good frame
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    send_seq(f1, 0);
    idle(3);
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_err", 32'(err_cnt - e0), 32'd0);
    chk("t1_we", 32'(we_cnt - w0), 32'd6);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_words", 32'(words_loaded), 32'd6);
    for (int i = 0; i < 6; i++) chk("t1_mem", 32'(dmem[i]), 32'(t1d[i]));

    // Bad checksum
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    q = f1;
    q[8] = 8'h1D;
    send_seq(q, 1);
    idle(3);
    chk("t2_done", 32'(done_cnt - d0), 32'd0);
    chk("t2_err", 32'(err_cnt - e0), 32'd1);
    chk("t2_we", 32'(we_cnt - w0), 32'd6);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    chk("t2_words", 32'(words_loaded), 32'd6);

    // Illegal LEN values, then recovery
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    send_seq('{8'hA5, 8'h00}, 0);
    idle(2);
    send_seq('{8'hA5, 8'h21}, 0);
    idle(2);
    chk("t3_err", 32'(err_cnt - e0), 32'd2);
    chk("t3_we", 32'(we_cnt - w0), 32'd0);
    send_seq(f1, 0);
    idle(3);
    chk("t3_done", 32'(done_cnt - d0), 32'd1);

    // Maximum LEN fills every address
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'(i * 3 + 1));
    send_seq(make_frame(q), 0);
    idle(3);
    chk("max_words", 32'(words_loaded), 32'd32);
    chk("max_mem31", 32'(dmem[31]), 32'h5E);
    chk("max_hold", 32'(cpu_hold), 32'd0);

    // Junk before frame is ignored
    d0 = done_cnt;
    send_seq('{8'h00, 8'hFF, 8'h5A}, 0);
    send_seq(f1, 0);
    idle(3);
    chk("t4_done", 32'(done_cnt - d0), 32'd1);
    chk("t4_words", 32'(words_loaded), 32'd6);

    // Timeout: gap of 7 survives, gap of 8 aborts
    d0 = done_cnt; e0 = err_cnt;
    foreach (f1[i]) send(f1[i], (i == 5) ? 7 : 0);
    idle(3);
    chk("t5_gap7_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    foreach (f1[i]) send(f1[i], (i == 5) ? 8 : 0);
    idle(3);
    chk("t5_gap8_err", 32'(err_cnt - e0), 32'd1);
    chk("t5_gap8_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    send(8'hA5, 0);
    send(8'h06, 8);
    idle(3);
    chk("t5_len_tmo", 32'(err_cnt - e0), 32'd2);

    // Asynchronous reset mid-frame
    send_seq('{8'hA5, 8'h06, 8'h11, 8'h22, 8'h33}, 0);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_addr", 32'(mem_addr), 32'd0);
    chk("t6_wdata", 32'(mem_wdata), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_words", 32'(words_loaded), 32'd0);
    chk("t6_mem0", 32'(dmem[0]), 32'h11);
    chk("t6_mem2", 32'(dmem[2]), 32'h33);
    idle(2);
    reset = 1'b1;
    idle(1);
    d0 = done_cnt;
    send_seq('{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09}, 0);
    idle(3);
    chk("t6_done", 32'(done_cnt - d0), 32'd1);
    chk("t6_words_after", 32'(words_loaded), 32'd3);

    // Random frames with random gaps
    for (int k = 0; k < 15; k++) begin
      bq_t fr;
      logic [7:0] jb;
      int n;
      n = int'($urandom_range(1, MAXW));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      fr = make_frame(q);
      if ($urandom_range(0, 3) == 0) fr[fr.size() - 1] = fr[fr.size() - 1] ^ 8'h01;
      jb = 8'($urandom);
      if (jb == 8'hA5) jb = 8'h00;
      send(jb, int'($urandom_range(0, 3)));
      send_seq(fr, -1);
      idle(int'($urandom_range(0, 3)));
    end

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
